// File: rtl/round_robin_arb_wlock.sv
// Round-robin switch-allocation arbiter with packet locking, per-requester
// weighted quanta and a downstream stall. Grant is combinational from the
// current state; token, quantum count, owner and lock state are registered.
module round_robin_arb_wlock #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 2,
    parameter bit LOCK_EN  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_p,
    input  logic [NUM_REQ-1:0]           req_in,
    input  logic [NUM_REQ-1:0]           tail_in,
    input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_in,
    input  logic                         stall_in,
    output logic [NUM_REQ-1:0]           grant_vec_out,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id_out,
    output logic                         grant_valid_out,
    output logic                         locked_out
);

    localparam int BITS_REQ = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [BITS_REQ-1:0] ID_ONE   = BITS_REQ'(1);
    localparam logic [BITS_REQ-1:0] ID_LAST  = BITS_REQ'(NUM_REQ - 1);
    localparam logic [WEIGHT_W:0]   CNT_ONE  = (WEIGHT_W + 1)'(1);
    localparam logic [NUM_REQ-1:0]  VEC_ONE  = NUM_REQ'(1);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    // Registered state
    logic [BITS_REQ-1:0] token_reg;
    logic [WEIGHT_W-1:0] cnt_reg;
    logic [BITS_REQ-1:0] owner_reg;
    arb_state_t          st_reg;

    // Per-requester weights unpacked for indexed access
    logic [WEIGHT_W-1:0] weight_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_weight
            assign weight_arr[gi] = weight_in[gi*WEIGHT_W +: WEIGHT_W];
        end
    endgenerate

    // Cyclic search result
    logic                win_found;
    logic [BITS_REQ-1:0] win_idx;
    int                  scan_pos;
    logic [BITS_REQ-1:0] scan_idx;

    // Grant decision
    logic [BITS_REQ-1:0] grant_sel;
    logic                grant_req;
    logic                grant_ok;
    logic                grant_tail;

    // Completion arithmetic
    logic [WEIGHT_W:0]   new_cnt;
    logic [WEIGHT_W:0]   w_eff;
    logic                quantum_done;
    logic [BITS_REQ-1:0] next_token;

    // Find the first requester at or after the token, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_pos = int'(token_reg) + k;
            if (scan_pos >= NUM_REQ) begin
                scan_pos = scan_pos - NUM_REQ;
            end
            scan_idx = BITS_REQ'(scan_pos);
            if (!win_found && req_in[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Select the candidate: the lock owner while locked, else the search winner
    always_comb begin
        grant_sel  = (st_reg == ST_LOCKED) ? owner_reg : win_idx;
        grant_req  = (st_reg == ST_LOCKED) ? req_in[owner_reg] : win_found;
        grant_ok   = grant_req && !stall_in && !rst_p;
        grant_tail = tail_in[grant_sel] || !LOCK_EN;
    end

    // Quantum bookkeeping for a packet completing this cycle
    always_comb begin
        new_cnt      = (grant_sel == token_reg) ? ({1'b0, cnt_reg} + CNT_ONE) : CNT_ONE;
        w_eff        = (weight_arr[grant_sel] == '0) ? CNT_ONE : {1'b0, weight_arr[grant_sel]};
        quantum_done = (new_cnt >= w_eff);
        next_token   = (grant_sel == ID_LAST) ? '0 : (grant_sel + ID_ONE);
    end

    // State update: only accepted grants move the arbiter; stall freezes everything
    always_ff @(posedge clk) begin
        if (rst_p) begin
            token_reg <= '0;
            cnt_reg   <= '0;
            owner_reg <= '0;
            st_reg    <= ST_ARB;
        end else if (grant_ok) begin
            if (grant_tail) begin
                // Packet completion: either keep priority or pass the token on
                st_reg <= ST_ARB;
                if (quantum_done) begin
                    token_reg <= next_token;
                    cnt_reg   <= '0;
                end else begin
                    token_reg <= grant_sel;
                    cnt_reg   <= new_cnt[WEIGHT_W-1:0];
                end
            end else if (st_reg == ST_ARB) begin
                // Head flit of a multi-flit packet: hold the grant until the tail
                st_reg    <= ST_LOCKED;
                owner_reg <= grant_sel;
            end
        end
    end

    assign grant_valid_out = grant_ok;
    assign grant_id_out    = grant_ok ? grant_sel : '0;
    assign grant_vec_out   = grant_ok ? (VEC_ONE << grant_sel) : '0;
    assign locked_out      = (st_reg == ST_LOCKED) && !rst_p;

endmodule

// File: doc/round_robin_arb_wlock.md
# round_robin_arb_wlock

Parametrised round-robin arbiter for switch allocation across NUM_REQ requesters, such as VC x VN slots of one input port. It adds three things to the plain rotate/FPA/rotate arbiter: packet locking (grant held from first accepted flit to tail), per-requester weighted quanta, and a downstream stall input. Grant generation is combinational from the current state; token, quantum and lock state are registered.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters.
- WEIGHT_W, 2, bit width of each per-requester weight and of the quantum counter.
- LOCK_EN, 1, enables packet locking. When 0, every grant is treated as a tail.

Derived: bits_REQ = Log2(NUM_REQ), minimum 1.

Ports:
- clk, input, 1, the single clock. All state updates on the rising edge.
- rst_p, input, 1, synchronous, active-high reset.
- req_in, input, NUM_REQ, request vector; bit i = requester i has a flit ready.
- tail_in, input, NUM_REQ, bit i = requester i's current flit is a packet tail.
- weight_in, input, NUM_REQ*WEIGHT_W, packets per turn for requester i, in bits [i*WEIGHT_W +: WEIGHT_W]. Value 0 is treated as 1.
- stall_in, input, 1, downstream cannot accept this cycle.
- grant_vec_out, output, NUM_REQ, one-hot grant, or all zero.
- grant_id_out, output, bits_REQ, index of the granted requester; 0 when no grant.
- grant_valid_out, output, 1, a grant is issued this cycle.
- locked_out, output, 1, arbiter is in LOCKED state.

## Operation
State registers:
- token: bits_REQ, priority pointer.
- cnt: WEIGHT_W, packets completed in the current quantum.
- owner: bits_REQ.
- st: ARB or LOCKED.

ARB state:
- Winner g = first i with req_in[i]=1, searching cyclically from token, then token+1, and so on, wrapping NUM_REQ-1 to 0.
- A grant is accepted when grant_valid_out=1 and stall_in=0.
- Accepted, tail_in[g]=0 and LOCK_EN=1: go to LOCKED, owner<=g. Token and cnt are unchanged.
- Accepted, tail_in[g]=1 or LOCK_EN=0: perform completion.

LOCKED state:
- Grant forced to owner if req_in[owner]=1. Otherwise there is no grant and the state is held (bubble inside the packet).
- Other requesters are never granted while LOCKED.
- Accepted flit with tail_in[owner]=1: perform completion, go to ARB.

Completion for requester g:
- new_cnt = (g==token) ? cnt+1 : 1.
- w = max(weight_in[g],1), sampled at the completion cycle only.
- If new_cnt >= w: token <= (g+1) mod NUM_REQ, cnt <= 0.
- Otherwise: token <= g, cnt <= new_cnt, so g keeps top priority.
- cnt never exceeds 2^WEIGHT_W - 1; no overflow is possible.
- A token holder that drops its request loses its quantum as soon as another requester completes a packet.

Stall:
- stall_in=1 forces grant_vec_out=0, grant_valid_out=0 and grant_id_out=0.
- All state is frozen; locked_out still reflects the state.

Reset:
- While rst_p=1, all outputs are forced to 0 combinationally.
- On the edge: token=0, cnt=0, owner=0, st=ARB. An in-flight packet lock is discarded.

## Timing
- Request to grant: 0 cycles (combinational). The state update is visible the next cycle.
- Packet of F flits with no stall and no bubbles holds the grant for F consecutive cycles. Priority moves on the cycle after the tail.
- req_in, tail_in and weight_in must be stable before the clock edge. They are sampled only on cycles where a grant is accepted.
- Single-flit packet: tail on the first flit gives completion in the same cycle, with no LOCKED cycle.
- Simultaneous stall_in=1 and tail: no completion; the tail is retried.
- Simultaneous rst_p=1 and any request: reset wins, and no grant is issued that cycle.

## Test plan
All scenarios use NUM_REQ=4, WEIGHT_W=2, LOCK_EN=1.
- **Basic rotation:** reset, then req_in=1111, tail_in=1111, weights all 1. Required: grant_id_out 0,1,2,3,0 over 5 cycles, grant_valid_out=1 each cycle, locked_out=0.
- **Packet lock:** req_in=0011; requester 0 sends a 3-flit packet with tail on flit 3. Required: grants 0,0,0,1; locked_out=1 in cycles 2-3 only.
- **Weighting:** weight0=3, weight1=1, req_in=0011, single-flit packets. Required: grants 0,0,0,1,0,0,0,1.
- **Stall mid-packet:** stall_in=1 for 2 cycles during flit 2 of a 3-flit packet. Required: grant_valid_out=0 in those cycles, locked_out=1, owner unchanged; then flits 2 and 3 granted to the same requester.
- **Owner bubble:** owner 0 drops req_in[0] for 2 cycles mid-packet while req_in[1]=1. Required: no grant in those cycles and locked_out=1; requester 1 is granted only after requester 0's tail.
- **Reset mid-packet:** rst_p=1 for 1 cycle while LOCKED with owner 2. Required: all outputs 0 that cycle; next cycle req_in=0010 gives grant_id_out=1 and locked_out=0.
